// File: rtl/memory_read_ctrl_if.sv
// Bus bundle for memory_read_ctrl: scheduler start, cell-memory read port B,
// outgoing beat stream and free-list return path.
interface memory_read_ctrl_if #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned BLOCK_BITS = 512
);
  logic                  start_i;
  logic [ADDR_W-1:0]     start_idx_i;
  logic                  start_ready_o;
  logic                  mem_re_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [BLOCK_BITS-1:0] mem_rdata_i;
  logic [63:0]           data_o;
  logic                  data_valid_o;
  logic                  data_begin_o;
  logic                  data_end_o;
  logic                  data_ready_i;
  logic                  fl_free_req_o;
  logic [ADDR_W-1:0]     fl_free_idx_o;
  logic                  fl_free_gnt_i;
  logic                  err_o;

  modport master (
    input  start_i, start_idx_i, mem_rdata_i, data_ready_i, fl_free_gnt_i,
    output start_ready_o, mem_re_o, mem_addr_o, data_o, data_valid_o,
           data_begin_o, data_end_o, fl_free_req_o, fl_free_idx_o, err_o
  );

  modport slave (
    output start_i, start_idx_i, mem_rdata_i, data_ready_i, fl_free_gnt_i,
    input  start_ready_o, mem_re_o, mem_addr_o, data_o, data_valid_o,
           data_begin_o, data_end_o, fl_free_req_o, fl_free_idx_o, err_o
  );
endinterface

// File: rtl/memory_read_ctrl.sv
// Walks a linked list of cells, streams 7x64-bit beats per cell and returns each cell to the free list.
// Optional MEM_RD_PREFETCH_EN: overlap next-cell read and pending free with emission of the current cell.
module memory_read_ctrl #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned BLOCK_BITS = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  memory_read_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, EMIT, FREE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     curr_idx_q, curr_idx_d;
  logic                  first_cell_q, first_cell_d;
  logic [BLOCK_BITS-1:0] cell_q, cell_d;
  logic [2:0]            beat_cnt_q, beat_cnt_d;
  logic                  ready_en_q;

  logic                  start_ready, mem_re, data_valid, data_begin, data_end, free_req, err;
  logic [ADDR_W-1:0]     mem_addr, free_idx;
  logic [BLOCK_BITS-1:0] cell_sh;
  logic [ADDR_W-1:0]     next_idx;
  logic                  eop, is_last;

`ifdef MEM_RD_PREFETCH_EN
  logic [BLOCK_BITS-1:0] pf_cell_q, pf_cell_d;
  logic                  pf_wait_q, pf_wait_d;
  logic                  issued_q, issued_d;
  logic                  pend_v_q, pend_v_d;
  logic [ADDR_W-1:0]     pend_idx_q, pend_idx_d;
  logic                  err_pend_q, err_pend_d;
`endif

  // Final beat index: eop cells end at last_beat (clamped to 6), others always at 6.
  function automatic logic [2:0] last_of(input logic [BLOCK_BITS-1:0] c);
    logic [2:0] lb;
    lb = c[ADDR_W+4:ADDR_W+2];
    if (!c[ADDR_W]) return 3'd6;
    return (lb > 3'd6) ? 3'd6 : lb;
  endfunction

  assign cell_sh  = cell_q << (64 * beat_cnt_q);
  assign next_idx = cell_q[ADDR_W-1:0];
  assign eop      = cell_q[ADDR_W];
  assign is_last  = (beat_cnt_q == last_of(cell_q));

  always_comb begin
    state_d      = state_q;
    curr_idx_d   = curr_idx_q;
    first_cell_d = first_cell_q;
    cell_d       = cell_q;
    beat_cnt_d   = beat_cnt_q;
    start_ready  = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = curr_idx_q;
    data_valid   = 1'b0;
    data_begin   = 1'b0;
    data_end     = 1'b0;
    free_req     = 1'b0;
    free_idx     = curr_idx_q;
    err          = 1'b0;
`ifdef MEM_RD_PREFETCH_EN
    pf_cell_d    = pf_wait_q ? bus.mem_rdata_i : pf_cell_q;
    pf_wait_d    = 1'b0;
    issued_d     = issued_q;
    pend_v_d     = pend_v_q;
    pend_idx_d   = pend_idx_q;
    err_pend_d   = err_pend_q;
`endif
    unique case (state_q)
      IDLE: begin
        start_ready = ready_en_q;
        if (ready_en_q && bus.start_i) begin
          curr_idx_d   = bus.start_idx_i;
          first_cell_d = 1'b1;
          state_d      = RD_REQ;
        end
      end
      RD_REQ: begin
        mem_re  = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        cell_d = bus.mem_rdata_i;
        if (!bus.mem_rdata_i[ADDR_W+1]) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          beat_cnt_d = '0;
          state_d    = EMIT;
`ifdef MEM_RD_PREFETCH_EN
          issued_d   = 1'b0;
`endif
        end
      end
      EMIT: begin
        data_valid = 1'b1;
`ifdef MEM_RD_PREFETCH_EN
        if (!issued_q) begin
          issued_d = 1'b1;
          if (!eop) begin
            mem_re    = 1'b1;
            mem_addr  = next_idx;
            pf_wait_d = 1'b1;
          end
        end
        if (pend_v_q) begin
          free_req = 1'b1;
          free_idx = pend_idx_q;
          if (bus.fl_free_gnt_i) pend_v_d = 1'b0;
        end
        // The one-entry free register must drain before another cell can retire.
        if (is_last && pend_v_q) data_valid = 1'b0;
`endif
        data_begin = data_valid && first_cell_q && (beat_cnt_q == 3'd0);
        data_end   = data_valid && eop && is_last;
        if (data_valid && bus.data_ready_i) begin
          if (is_last) begin
            first_cell_d = 1'b0;
`ifdef MEM_RD_PREFETCH_EN
            if (eop) begin
              state_d = FREE;
            end else if (!pf_cell_q[ADDR_W+1]) begin
              err_pend_d = 1'b1;
              state_d    = FREE;
            end else begin
              pend_v_d   = 1'b1;
              pend_idx_d = curr_idx_q;
              curr_idx_d = next_idx;
              cell_d     = pf_cell_q;
              beat_cnt_d = '0;
              issued_d   = 1'b0;
            end
`else
            state_d = FREE;
`endif
          end else begin
            beat_cnt_d = beat_cnt_q + 3'd1;
          end
        end
      end
      FREE: begin
        free_req = 1'b1;
        if (bus.fl_free_gnt_i) begin
          if (eop) begin
            state_d = IDLE;
          end else begin
            curr_idx_d = next_idx;
            state_d    = RD_REQ;
          end
`ifdef MEM_RD_PREFETCH_EN
          if (err_pend_q) begin
            err        = 1'b1;
            err_pend_d = 1'b0;
            state_d    = IDLE;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      curr_idx_q   <= '0;
      first_cell_q <= 1'b0;
      cell_q       <= '0;
      beat_cnt_q   <= '0;
      ready_en_q   <= 1'b0;
`ifdef MEM_RD_PREFETCH_EN
      pf_cell_q    <= '0;
      pf_wait_q    <= 1'b0;
      issued_q     <= 1'b0;
      pend_v_q     <= 1'b0;
      pend_idx_q   <= '0;
      err_pend_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      curr_idx_q   <= curr_idx_d;
      first_cell_q <= first_cell_d;
      cell_q       <= cell_d;
      beat_cnt_q   <= beat_cnt_d;
      ready_en_q   <= 1'b1;
`ifdef MEM_RD_PREFETCH_EN
      pf_cell_q    <= pf_cell_d;
      pf_wait_q    <= pf_wait_d;
      issued_q     <= issued_d;
      pend_v_q     <= pend_v_d;
      pend_idx_q   <= pend_idx_d;
      err_pend_q   <= err_pend_d;
`endif
    end
  end

  assign bus.start_ready_o = start_ready;
  assign bus.mem_re_o      = mem_re;
  assign bus.mem_addr_o    = mem_addr;
  assign bus.data_o        = (state_q == EMIT) ? cell_sh[BLOCK_BITS-1 -: 64] : '0;
  assign bus.data_valid_o  = data_valid;
  assign bus.data_begin_o  = data_begin;
  assign bus.data_end_o    = data_end;
  assign bus.fl_free_req_o = free_req;
  assign bus.fl_free_idx_o = free_idx;
  assign bus.err_o         = err;
endmodule

// File: tb/tb_memory_read_ctrl.sv
// Randomised bench for memory_read_ctrl: a cell-list model predicts beats, reads, frees and errors.
module tb_memory_read_ctrl;
  localparam int unsigned A  = 10;
  localparam int unsigned BB = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  memory_read_ctrl_if #(.ADDR_W(A), .BLOCK_BITS(BB)) bus ();
  memory_read_ctrl #(.ADDR_W(A), .BLOCK_BITS(BB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {logic [63:0] data; logic b; logic e;} beat_t;

  logic [BB-1:0] mem [0:(1<<A)-1];
  beat_t         exp_beats[$];
  logic [A-1:0]  exp_free[$];
  logic [A-1:0]  exp_rd[$];
  logic [A-1:0]  plist[$];
  int            exp_err = 0;
  int            exp_span = 0;
  bit            timing_on = 0;
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            ready_pct = 100;
  int            gnt_delay = 0;

  bit            stalled, fheld, want_re, want_dv, err_prev;
  beat_t         sv_beat;
  logic [A-1:0]  sv_fidx;
  int            st_cyc, idle_due;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void flush_model();
    exp_beats.delete(); exp_free.delete(); exp_rd.delete();
    exp_err = 0; stalled = 0; fheld = 0; want_re = 0; want_dv = 0; err_prev = 0; idle_due = -1;
  endfunction

  function automatic bit idle_now();
    return exp_beats.size() == 0 && exp_free.size() == 0 && exp_rd.size() == 0 &&
           exp_err == 0 && bus.start_ready_o === 1'b1;
  endfunction

  // Lay the packet in plist out in memory and derive everything the controller must do with it.
  task automatic build(input int unsigned lb, input int bad_cell);
    logic [63:0] b [7];
    logic [63:0] ft;
    bit          lst;
    int          nb;
    for (int c = 0; c < plist.size(); c++) begin
      lst = (c == plist.size() - 1);
      for (int j = 0; j < 7; j++) b[j] = {$urandom, $urandom};
      ft = '0;
      ft[A-1:0]   = lst ? A'($urandom) : plist[c+1];
      ft[A]       = lst;
      ft[A+1]     = (c != bad_cell);
      ft[A+4:A+2] = lst ? 3'(lb) : 3'($urandom);
      mem[plist[c]] = {b[0], b[1], b[2], b[3], b[4], b[5], b[6], ft};
      exp_rd.push_back(plist[c]);
      if (c == bad_cell) begin
        exp_err = 1;
        break;
      end
      nb = lst ? ((lb > 6) ? 7 : int'(lb) + 1) : 7;
      for (int j = 0; j < nb; j++) exp_beats.push_back('{b[j], (c == 0 && j == 0), (lst && j == nb - 1)});
      exp_free.push_back(plist[c]);
      if (lst) exp_span = 3 + 10 * c + nb - 1;
    end
    timing_on = (bad_cell < 0) && ready_pct == 100 && gnt_delay == 0;
  endtask

  task automatic pick_list(input int n);
    logic [A-1:0] c;
    bit dup;
    plist.delete();
    while (plist.size() < n) begin
      c = A'($urandom);
      dup = 0;
      foreach (plist[i]) if (plist[i] == c) dup = 1;
      if (!dup) plist.push_back(c);
    end
  endtask

  task automatic start_only(input logic [A-1:0] head);
    bit acc = 0;
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.start_idx_i = head;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = bus.start_ready_o;
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.start_idx_i = A'($urandom);
    chk("start_accept", 64'(acc), 64'd1);
  endtask

  task automatic run_pkt(input logic [A-1:0] head);
    bit done = 0;
    start_only(head);
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk); #1;
      done = idle_now();
    end
    chk("pkt_complete", 64'(done), 64'd1);
    if (!done) flush_model();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start_ready"}, 64'(bus.start_ready_o), 64'd0);
    chk({tag, "_mem_re"},      64'(bus.mem_re_o), 64'd0);
    chk({tag, "_mem_addr"},    64'(bus.mem_addr_o), 64'd0);
    chk({tag, "_data"},        bus.data_o, 64'd0);
    chk({tag, "_valid"},       64'(bus.data_valid_o), 64'd0);
    chk({tag, "_begin_end"},   64'({bus.data_begin_o, bus.data_end_o}), 64'd0);
    chk({tag, "_free"},        64'({bus.fl_free_req_o, bus.fl_free_idx_o}), 64'd0);
    chk({tag, "_err"},         64'(bus.err_o), 64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Environment: port-B memory with one-cycle latency, random backpressure, delayed free grants.
  initial begin : drive
    bit           rd_pend = 0;
    logic [A-1:0] rd_addr = '0;
    int           gw = 0;
    bus.data_ready_i = 1'b0; bus.fl_free_gnt_i = 1'b0; bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_rdata_i = rd_pend ? mem[rd_addr] : {16{$urandom}};
      rd_pend = bus.mem_re_o; rd_addr = bus.mem_addr_o;
      bus.data_ready_i = ($urandom_range(99) < ready_pct);
      if (bus.fl_free_gnt_i || !bus.fl_free_req_o) gw = 0;
      if (bus.fl_free_req_o) gw++;
      bus.fl_free_gnt_i = bus.fl_free_req_o && (gw > gnt_delay);
    end
  end

  initial begin : compare
    beat_t        eb;
    logic [A-1:0] ef;
    flush_model();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.start_i && bus.start_ready_o) begin
          st_cyc = cyc; want_re = 1; want_dv = (exp_beats.size() > 0);
        end
        if (bus.mem_re_o) begin
          chk("rd_expected", 64'(exp_rd.size() > 0), 64'd1);
          if (exp_rd.size() > 0) chk("rd_addr", 64'(bus.mem_addr_o), 64'(exp_rd.pop_front()));
          if (want_re) begin chk("rd_latency", 64'(cyc - st_cyc), 64'd1); want_re = 0; end
          chk("rd_while_free_pending", 64'(bus.fl_free_req_o), 64'd0);
        end
        if (bus.data_valid_o) begin
          if (want_dv) begin chk("first_beat_latency", 64'(cyc - st_cyc), 64'd3); want_dv = 0; end
          if (stalled) begin
            chk("stall_data", bus.data_o, sv_beat.data);
            chk("stall_frame", 64'({bus.data_begin_o, bus.data_end_o}), 64'({sv_beat.b, sv_beat.e}));
          end
          if (bus.data_ready_i) begin
            stalled = 0;
            chk("beat_expected", 64'(exp_beats.size() > 0), 64'd1);
            if (exp_beats.size() > 0) begin
              eb = exp_beats.pop_front();
              chk("beat_data", bus.data_o, eb.data);
              chk("beat_begin", 64'(bus.data_begin_o), 64'(eb.b));
              chk("beat_end", 64'(bus.data_end_o), 64'(eb.e));
              if (eb.e && timing_on) chk("end_beat_cycle", 64'(cyc - st_cyc), 64'(exp_span));
            end
          end else begin
            stalled = 1; sv_beat = '{bus.data_o, bus.data_begin_o, bus.data_end_o};
          end
        end else if (stalled) begin
          chk("stall_valid_held", 64'd0, 64'd1);
          stalled = 0;
        end
        if (bus.fl_free_req_o) begin
          if (fheld) chk("free_idx_held", 64'(bus.fl_free_idx_o), 64'(sv_fidx));
          if (bus.fl_free_gnt_i) begin
            fheld = 0;
            chk("free_expected", 64'(exp_free.size() > 0), 64'd1);
            if (exp_free.size() > 0) begin
              ef = exp_free.pop_front();
              chk("free_idx", 64'(bus.fl_free_idx_o), 64'(ef));
              if (exp_free.size() == 0 && exp_err == 0) idle_due = cyc + 1;
            end
          end else begin
            fheld = 1; sv_fidx = bus.fl_free_idx_o;
          end
        end else if (fheld) begin
          chk("free_req_held", 64'd0, 64'd1);
          fheld = 0;
        end
        if (err_prev) chk("err_one_cycle", 64'(bus.err_o), 64'd0);
        if (bus.err_o && !err_prev) begin
          chk("err_expected", 64'(exp_err), 64'd1);
          exp_err = 0; idle_due = cyc + 1;
        end
        err_prev = bus.err_o;
        if (cyc == idle_due) chk("idle_after_done", 64'(bus.start_ready_o), 64'd1);
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, lb, bc;
    bus.start_i = 1'b0; bus.start_idx_i = '0;
    #1 rst_n = 1'b0;
    #2 chk_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("ready_before_first_clk", 64'(bus.start_ready_o), 64'd0);
    @(posedge clk); #1 chk("ready_after_first_clk", 64'(bus.start_ready_o), 64'd1);

    // 5 -> 9 -> 2, eop last_beat=3, full throughput
    plist = '{10'd5, 10'd9, 10'd2};
    build(3, -1);
    chk("model_t1_beats", 64'(exp_beats.size()), 64'd18);
    chk("model_t1_span", 64'(exp_span), 64'd26);
    chk("model_t1_free_order", 64'({exp_free[0], exp_free[1], exp_free[2]}), 64'({10'd5, 10'd9, 10'd2}));
    chk("model_t1_end_flag", 64'({exp_beats[0].b, exp_beats[17].e, exp_beats[16].e}), 64'b110);
    run_pkt(10'd5);

    // Single cell, last_beat=0
    plist = '{10'd33};
    build(0, -1);
    chk("model_t2_beats", 64'(exp_beats.size()), 64'd1);
    chk("model_t2_frame", 64'({exp_beats[0].b, exp_beats[0].e}), 64'b11);
    run_pkt(10'd33);

    // last_beat=7 is clamped to 6
    plist = '{10'd700};
    build(7, -1);
    chk("model_clamp_beats", 64'(exp_beats.size()), 64'd7);
    run_pkt(10'd700);

    // Two cells under 50% backpressure
    ready_pct = 50;
    for (int r = 0; r < 3; r++) begin
      pick_list(2); build(unsigned'($urandom_range(7)), -1); run_pkt(plist[0]);
    end
    ready_pct = 100;

    // Free grant delayed 4 cycles
    gnt_delay = 4;
    pick_list(3); build(5, -1); run_pkt(plist[0]);
    gnt_delay = 0;

    // Footer valid=0 on the second cell
    pick_list(3); build(2, 1);
    chk("model_err_frees", 64'(exp_free.size()), 64'd1);
    chk("model_err_reads", 64'(exp_rd.size()), 64'd2);
    run_pkt(plist[0]);

    // Randomised packets
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(4, 1);
      lb = $urandom_range(7);
      bc = ($urandom_range(3) == 0) ? $urandom_range(n - 1) : -1;
      ready_pct = ($urandom_range(1) == 0) ? 100 : $urandom_range(90, 30);
      gnt_delay = $urandom_range(3);
      pick_list(n); build(unsigned'(lb), bc); run_pkt(plist[0]);
    end
    ready_pct = 100; gnt_delay = 0;

    // Reset in the middle of EMIT
    pick_list(2); build(4, -1);
    start_only(plist[0]);
    for (int k = 0; k < 20 && !bus.data_valid_o; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    flush_model();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("midreset_ready_low", 64'(bus.start_ready_o), 64'd0);
    @(posedge clk); #1 chk("midreset_ready_high", 64'(bus.start_ready_o), 64'd1);
    plist = '{10'd7, 10'd300};
    build(6, -1);
    run_pkt(10'd7);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
